periph_rx_arbiter: RTL and testbench



---
 rtl/lycan_globals.sv | 25 ++
 rtl/rr_priority_pick.sv | 30 +++
 rtl/periph_rx_arbiter.sv | 108 ++++++++++
 tb/tb_periph_rx_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lycan_globals.sv
// Shared Lycan definitions: USB packet layout, peripheral word fields and arbiter types.
// Peripheral words are 29 bits; the arbiter prepends a 3-bit source address to make 32.
package lycan_globals;

    localparam int usb_packet_width       = 32;
    localparam int periph_address_width   = 3;
    localparam int periph_word_width      = usb_packet_width - periph_address_width;
    localparam int inputs_per_peripheral  = 1;
    localparam int outputs_per_peripheral = 1;

    localparam int config_flag_bit = 28;
    localparam int valid_bytes_msb = 27;
    localparam int valid_bytes_lsb = 26;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // A data word claiming zero valid bytes carries nothing and is discarded.
    function automatic logic is_malformed(input logic [periph_word_width-1:0] word);
        return !word[config_flag_bit] && (word[valid_bytes_msb:valid_bytes_lsb] == 2'b00);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first asserted request at or above rr_ptr, wrapping past the top index.
module rr_priority_pick
    import lycan_globals::*;
#(
    parameter int N = 8,
    parameter int W = periph_address_width
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] rr_ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W-1:0] cand;

    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int i = 0; i < N; i++) begin
            cand = W'((int'(rr_ptr) + i) % N);
            if (!any && req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/periph_rx_arbiter.sv
// Merges per-peripheral RX FIFOs into the USB TX stream, tagging each packet with its source
// address; round-robin between peripherals with up to BURST_LEN packets per grant.
module periph_rx_arbiter
    import lycan_globals::*;
#(
    parameter int NUM_PERIPH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic [NUM_PERIPH-1:0][periph_word_width-1:0]   periph_rx_data,
    input  logic [NUM_PERIPH-1:0]                          periph_rx_empty,
    output logic [NUM_PERIPH-1:0]                          periph_rx_rden,
    output logic [usb_packet_width-1:0]                    usb_data,
    output logic                                           usb_wren,
    input  logic                                           usb_full,
    output logic [15:0]                                    drop_count
);

    localparam int AW = periph_address_width;
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_PERIPH - 1);

    arb_state_t                   state, state_nxt;
    logic [AW-1:0]                rr_ptr, grant, pick_idx;
    logic                         pick_any;
    logic [BW-1:0]                burst_cnt;
    logic                         out_valid, can_accept;
    logic                         pop, release_grant, head_empty;
    logic [periph_word_width-1:0] head;
    logic [NUM_PERIPH-1:0]        req;

    assign req        = ~periph_rx_empty;
    assign head       = periph_rx_data[grant];
    assign head_empty = periph_rx_empty[grant];
    assign usb_wren   = out_valid & ~usb_full;
    assign can_accept = ~out_valid | usb_wren;

    rr_priority_pick #(.N(NUM_PERIPH), .W(AW)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_nxt      = state;
        periph_rx_rden = '0;
        pop            = 1'b0;
        release_grant  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) state_nxt = GRANT;
            end
            GRANT: begin
                if (head_empty) begin
                    release_grant = 1'b1;
                    state_nxt     = IDLE;
                end else if (can_accept) begin
                    pop                   = 1'b1;
                    periph_rx_rden[grant] = 1'b1;
                    if (burst_cnt == BW'(BURST_LEN - 1)) begin
                        release_grant = 1'b1;
                        state_nxt     = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_any) begin
                grant     <= pick_idx;
                burst_cnt <= '0;
            end
            if (pop) burst_cnt <= burst_cnt + 1'b1;
            if (release_grant) rr_ptr <= (grant == LAST_IDX) ? '0 : grant + 1'b1;
        end
    end

    // A drop loads nothing: out_valid still clears if the held word drains this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            usb_data   <= '0;
            out_valid  <= 1'b0;
            drop_count <= '0;
        end else begin
            if (pop && !is_malformed(head)) begin
                usb_data  <= {grant, head};
                out_valid <= 1'b1;
            end else if (usb_wren) begin
                out_valid <= 1'b0;
            end
            if (pop && is_malformed(head) && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_periph_rx_arbiter.sv
// Directed bench for periph_rx_arbiter: single-packet vector table plus fairness,
// backpressure, wrap-around and mid-stream reset sequences against a queue-based FIFO model.
module tb_periph_rx_arbiter;

    localparam int NP = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NP-1:0][28:0]  periph_rx_data = '0;
    logic [NP-1:0]        periph_rx_empty = '1;
    logic [NP-1:0]        periph_rx_rden;
    logic [31:0]          usb_data;
    logic                 usb_wren;
    logic                 usb_full = 1'b0;
    logic [15:0]          drop_count;

    int checks = 0;
    int failures = 0;

    logic [28:0]   fifo [NP][$];
    logic [31:0]   obs [$];
    int            obs_cyc [$];
    int            rden_cnt [NP];
    int            cyc = 0;
    logic [NP-1:0] pop_mask = '0;

    typedef struct {
        int          periph;
        logic [28:0] word;
        int          exp_writes;
        logic [31:0] exp_data;
        logic [15:0] exp_drop;
    } vec_t;

    vec_t vecs [9];

    periph_rx_arbiter #(.NUM_PERIPH(NP), .BURST_LEN(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .periph_rx_data  (periph_rx_data),
        .periph_rx_empty (periph_rx_empty),
        .periph_rx_rden  (periph_rx_rden),
        .usb_data        (usb_data),
        .usb_wren        (usb_wren),
        .usb_full        (usb_full),
        .drop_count      (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // FWFT FIFO model: pops requested before the edge are applied just after it.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NP; i++)
            if (pop_mask[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
        for (int i = 0; i < NP; i++) begin
            periph_rx_empty[i] = (fifo[i].size() == 0);
            periph_rx_data[i]  = (fifo[i].size() == 0) ? 29'h0 : fifo[i][0];
        end
    end

    always @(negedge clk) begin
        pop_mask = periph_rx_rden;
        cyc++;
        if (rst_n) begin
            if (usb_wren) begin
                obs.push_back(usb_data);
                obs_cyc.push_back(cyc);
            end
            for (int i = 0; i < NP; i++) rden_cnt[i] += int'(periph_rx_rden[i]);
            check("rden_onehot0", $onehot0(periph_rx_rden), 1'b1);
            check("wren_while_full", usb_wren & usb_full, 1'b0);
        end
    end

    function automatic bit any_pending();
        for (int i = 0; i < NP; i++)
            if (fifo[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_obs();
        obs.delete();
        obs_cyc.delete();
        for (int i = 0; i < NP; i++) rden_cnt[i] = 0;
    endtask

    task automatic drain(input string name);
        int budget = 400;
        while (any_pending() && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
        end
        check({name, "_done_in_time"}, budget > 0, 1'b1);
        repeat (6) @(posedge clk);
        #2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          budget;
        int          n_before;
        logic [31:0] snap;
        logic [31:0] exp_q [$];
        int          gaps [12];
        logic [28:0] w;

        vecs[0] = '{5, 29'h0C00_00AB, 1, 32'hAC00_00AB, 16'd0};
        vecs[1] = '{2, 29'h0000_1234, 0, 32'h0,         16'd1};
        vecs[2] = '{2, 29'h1C00_0008, 1, 32'h5C00_0008, 16'd1};
        vecs[3] = '{0, 29'h0400_0001, 1, 32'h0400_0001, 16'd1};
        vecs[4] = '{7, 29'h0800_FFFF, 1, 32'hE800_FFFF, 16'd1};
        // Bits 25:24 set but 27:26 clear: still zero valid bytes.
        vecs[5] = '{3, 29'h0300_00AB, 0, 32'h0,         16'd2};
        vecs[6] = '{6, 29'h1000_0000, 1, 32'hD000_0000, 16'd2};
        vecs[7] = '{1, 29'h1FFF_FFFF, 1, 32'h3FFF_FFFF, 16'd2};
        vecs[8] = '{4, 29'h03FF_FFFF, 0, 32'h0,         16'd3};
        gaps = '{0, 1, 1, 1, 2, 1, 1, 1, 2, 1, 3, 1};

        // Reset state.
        rst_n = 1'b0;
        usb_full = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_usb_data", usb_data, 32'h0);
        check("reset_usb_wren", usb_wren, 1'b0);
        check("reset_rden", periph_rx_rden, 8'h0);
        check("reset_drop_count", drop_count, 16'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Single-packet vectors.
        for (int v = 0; v < 9; v++) begin
            clear_obs();
            fifo[vecs[v].periph].push_back(vecs[v].word);
            drain($sformatf("vec%0d", v));
            check($sformatf("vec%0d_writes", v), obs.size(), vecs[v].exp_writes);
            if (vecs[v].exp_writes == 1 && obs.size() > 0)
                check($sformatf("vec%0d_data", v), obs[0], vecs[v].exp_data);
            check($sformatf("vec%0d_drop_count", v), drop_count, vecs[v].exp_drop);
            check($sformatf("vec%0d_pops", v), rden_cnt[vecs[v].periph], 1);
        end

        // Fairness: two peripherals with 6 packets each, rr_ptr=5 so p0 wins first.
        clear_obs();
        for (int k = 0; k < 6; k++) begin
            fifo[0].push_back(29'h0400_0000 | 29'(k));
            fifo[1].push_back(29'h0800_0100 | 29'(k));
        end
        drain("fair");
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back({3'd0, 29'h0400_0000 | 29'(k)});
        for (int k = 0; k < 4; k++) exp_q.push_back({3'd1, 29'h0800_0100 | 29'(k)});
        for (int k = 4; k < 6; k++) exp_q.push_back({3'd0, 29'h0400_0000 | 29'(k)});
        for (int k = 4; k < 6; k++) exp_q.push_back({3'd1, 29'h0800_0100 | 29'(k)});
        check("fair_count", obs.size(), 12);
        for (int i = 0; i < 12 && i < obs.size(); i++) begin
            check($sformatf("fair_data%0d", i), obs[i], exp_q[i]);
            if (i > 0) check($sformatf("fair_gap%0d", i), obs_cyc[i] - obs_cyc[i-1], gaps[i]);
        end

        // Backpressure mid-burst on p3.
        clear_obs();
        for (int k = 0; k < 8; k++) fifo[3].push_back(29'h0C00_0300 | 29'(k));
        budget = 100;
        while (obs.size() < 2 && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
        end
        check("bp_started", budget > 0, 1'b1);
        usb_full = 1'b1;
        snap = usb_data;
        n_before = obs.size();
        repeat (10) begin
            @(negedge clk);
            check("bp_no_rden", periph_rx_rden, 8'h0);
            check("bp_data_hold", usb_data, snap);
        end
        check("bp_no_writes", obs.size(), n_before);
        @(posedge clk);
        #2;
        usb_full = 1'b0;
        drain("bp");
        check("bp_count", obs.size(), 8);
        for (int k = 0; k < 8 && k < obs.size(); k++) begin
            w = 29'h0C00_0300 | 29'(k);
            check($sformatf("bp_data%0d", k), obs[k], {3'd3, w});
        end

        // Wrap: serve p6 so rr_ptr lands on 7, then request 7 and 0 together.
        clear_obs();
        fifo[6].push_back(29'h0400_0066);
        drain("wrap_setup");
        check("wrap_setup_count", obs.size(), 1);
        clear_obs();
        fifo[0].push_back(29'h0400_0070);
        fifo[7].push_back(29'h0400_0077);
        drain("wrap");
        check("wrap_count", obs.size(), 2);
        if (obs.size() == 2) begin
            check("wrap_first_p7", obs[0], 32'hE400_0077);
            check("wrap_second_p0", obs[1], 32'h0400_0070);
        end

        // Reset while a packet is held behind usb_full.
        clear_obs();
        usb_full = 1'b1;
        fifo[4].push_back(29'h0400_0044);
        budget = 50;
        while (rden_cnt[4] < 1 && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
        end
        check("rst_pop_seen", budget > 0, 1'b1);
        @(posedge clk);
        #2;
        check("rst_held_data", usb_data, 32'h8400_0044);
        rst_n = 1'b0;
        usb_full = 1'b0;
        #1;
        check("rst_async_usb_data", usb_data, 32'h0);
        check("rst_async_usb_wren", usb_wren, 1'b0);
        check("rst_async_rden", periph_rx_rden, 8'h0);
        check("rst_async_drop_count", drop_count, 16'h0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        clear_obs();
        fifo[1].push_back(29'h0800_0011);
        drain("post_rst");
        check("post_rst_count", obs.size(), 1);
        if (obs.size() > 0) check("post_rst_data", obs[0], 32'h2800_0011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
